// File: rtl/ts_table_scheduler.sv
// ---------------------------------------------------------------------------
// ts_table_scheduler
//
// Decides when a PSI/SI table (PAT, PMT, SDT) goes into the T2-MI transport
// stream. Every INTERVAL T2-MI packets a table slot falls due. The packetizer
// sees TABLE_READY, accepts the slot with START, and the scheduler then
// kicks the table generator with TBL_GO and watches for TBL_DONE. If the
// generator does not finish within TIMEOUT cycles, the transmission is
// aborted. Either way the rotation moves on to the next table.
//
// Parameters
//   INTERVAL     T2-MI packets between table slots          (1..65535)
//   TIMEOUT      clock cycles allowed for one table          (2..65535)
//
// Optional feature
//   TS_SDT_TABLE_EN  when defined the rotation is PAT -> PMT -> SDT;
//                    otherwise it is PAT -> PMT and TBL_SEL never reads 2.
//
// Ports
//   CLK          clock, everything on the rising edge
//   RST          synchronous active-low reset
//   PKT_DONE     pulse, end of one T2-MI TS packet
//   START        pulse, packetizer accepts the pending table
//   TBL_DONE     pulse, table generator sent the last byte
//   TABLE_READY  high while a table slot is waiting for START
//   TABLE_SENT   pulse, granted table finished or aborted
//   TBL_GO       pulse, start the table generator
//   TBL_SEL      table index, 0=PAT 1=PMT 2=SDT
//   ERR_TIMEOUT  pulse, table transmission aborted by the watchdog
//   MISSED       saturating count of slots dropped while busy
//   state_mon    current FSM state (0 IDLE, 1 PENDING, 2 SEND, 3 WAIT_DONE)
// ---------------------------------------------------------------------------
module ts_table_scheduler #(
    parameter int unsigned INTERVAL = 16,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PKT_DONE,
    input  logic       START,
    input  logic       TBL_DONE,
    output logic       TABLE_READY,
    output logic       TABLE_SENT,
    output logic       TBL_GO,
    output logic [1:0] TBL_SEL,
    output logic       ERR_TIMEOUT,
    output logic [7:0] MISSED,
    output logic [1:0] state_mon
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PENDING   = 2'd1,
        S_SEND      = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_e;

    localparam logic [15:0] PKT_LAST = 16'(INTERVAL - 1);
    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);
    localparam logic [7:0]  MISSED_MAX = 8'hFF;

`ifdef TS_SDT_TABLE_EN
    localparam logic [1:0] ROT_LAST = 2'd2;
`else
    localparam logic [1:0] ROT_LAST = 2'd1;
`endif

    state_e      state_q, state_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] wd_q, wd_d;
    logic [1:0]  rot_q, rot_d;
    logic [7:0]  missed_q, missed_d;

    logic slot_due;
    logic wd_expired;
    logic finish;
    logic abort;

    // -----------------------------------------------------------------------
    // Event decode shared by the FSM and the datapath.
    // -----------------------------------------------------------------------
    always_comb begin
        slot_due   = PKT_DONE && (pkt_cnt_q == PKT_LAST);
        wd_expired = (state_q == S_WAIT_DONE) && (wd_q == WD_LAST);
        // TBL_DONE wins over a simultaneous expiry: that is a clean finish.
        finish     = (state_q == S_WAIT_DONE) && (TBL_DONE || wd_expired);
        abort      = wd_expired && !TBL_DONE;
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: the reset is sampled on the clock edge like any other input, so it
    // lives inside the clocked branch and no asynchronous term appears in the
    // sensitivity list.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: flops are always assigned with <= so every register sees
            // the pre-edge value of every other register.
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d
        // unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (slot_due) begin
                    state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                if (START) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // A slot arriving exactly as the table completes is not
                // a miss; it is queued straight away.
                if (finish) begin
                    state_d = slot_due ? S_PENDING : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers: packet counter, watchdog, rotation, miss counter.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            pkt_cnt_q <= '0;
            wd_q      <= '0;
            rot_q     <= '0;
            missed_q  <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            wd_q      <= wd_d;
            rot_q     <= rot_d;
            missed_q  <= missed_d;
        end
    end

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        wd_d      = wd_q;
        rot_d     = rot_q;
        missed_d  = missed_q;

        // Packets are counted regardless of state or transition.
        if (PKT_DONE) begin
            pkt_cnt_d = slot_due ? 16'd0 : pkt_cnt_q + 16'd1;
        end

        // Watchdog restarts at the go pulse and runs only while waiting.
        // It can never pass WD_LAST because expiry leaves WAIT_DONE.
        if (state_q == S_SEND) begin
            wd_d = 16'd0;
        end else if (state_q == S_WAIT_DONE) begin
            wd_d = wd_q + 16'd1;
        end

        if (finish) begin
            rot_d = (rot_q == ROT_LAST) ? 2'd0 : rot_q + 2'd1;
        end

        // Only one slot is ever queued; further slots are dropped and
        // counted, except the one that lands on the completion cycle.
        if (slot_due && (state_q != S_IDLE) && !finish &&
            (missed_q != MISSED_MAX)) begin
            missed_d = missed_q + 8'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. Pulses are masked while RST is low so a reset in the middle
    // of a transmission abandons it without a completion or error pulse.
    // -----------------------------------------------------------------------
    always_comb begin
        TABLE_READY = (state_q == S_PENDING);
        TBL_GO      = RST && (state_q == S_SEND);
        TABLE_SENT  = RST && finish;
        ERR_TIMEOUT = RST && abort;
        TBL_SEL     = rot_q;
        MISSED      = missed_q;
        state_mon   = state_q;
    end

`ifndef SYNTHESIS
    a_err_has_sent : assert property (@(posedge CLK) disable iff (!RST)
        ERR_TIMEOUT |-> TABLE_SENT);

    a_sel_range : assert property (@(posedge CLK) disable iff (!RST)
        TBL_SEL <= ROT_LAST);

    a_go_single : assert property (@(posedge CLK) disable iff (!RST)
        TBL_GO |=> !TBL_GO);
`endif

endmodule

// File: doc/ts_table_scheduler.md
TS_TABLE_SCHEDULER -- requirements
Module: ts_table_scheduler

Interface
REQ-001 SHALL have parameter INTERVAL, default 16: T2-MI packets between table insertions; legal range 1..65535.
REQ-002 SHALL have parameter TIMEOUT, default 4096: clock cycles allowed for one table transmission; legal range 2..65535.
REQ-003 SHALL have port CLK, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port RST, input, 1: reset; synchronous, active-low.
REQ-005 SHALL have port PKT_DONE, input, 1: one-cycle pulse from the packetizer at the end of each T2-MI TS packet.
REQ-006 SHALL have port START, input, 1: one-cycle pulse from the packetizer accepting a pending table.
REQ-007 SHALL have port TBL_DONE, input, 1: one-cycle pulse from the table generator when the last table byte has been sent.
REQ-008 SHALL have port TABLE_READY, output, 1: a table is due; the packetizer samples it at the packet boundary.
REQ-009 SHALL have port TABLE_SENT, output, 1: one-cycle pulse when the granted table is finished or aborted.
REQ-010 SHALL have port TBL_GO, output, 1: one-cycle start pulse to the table generator.
REQ-011 SHALL have port TBL_SEL, output, 2: selects the table; 0=PAT, 1=PMT, 2=SDT; stable from TBL_GO through TBL_DONE.
REQ-012 SHALL have port ERR_TIMEOUT, output, 1: one-cycle pulse on a transmission abort.
REQ-013 SHALL have port MISSED, output, 8: count of table slots skipped because the previous slot was still pending; saturates at 255.
REQ-014 SHALL have port state_mon, output, 2: current FSM state encoding.

Function
REQ-015 FSM SHALL have states IDLE=0, PENDING=1, SEND=2, WAIT_DONE=3.
REQ-016 pkt_cnt (16 bit) SHALL increment on each PKT_DONE; on PKT_DONE with pkt_cnt==INTERVAL-1 it SHALL wrap to 0 and raise "slot due".
REQ-017 IDLE + slot due -> PENDING the next cycle; TABLE_READY SHALL be 1 exactly while the state is PENDING.
REQ-018 Slot due while in PENDING, SEND or WAIT_DONE SHALL increment MISSED (saturating) and SHALL NOT queue a second slot.
REQ-019 PENDING + START -> SEND; START outside PENDING SHALL be ignored.
REQ-020 SEND SHALL last exactly one cycle: TBL_GO=1, TBL_SEL=current rotation index, watchdog cleared; next state WAIT_DONE.
REQ-021 WAIT_DONE + TBL_DONE -> IDLE; TABLE_SENT SHALL pulse in the same cycle as the transition, and the rotation SHALL advance.
REQ-022 Rotation order SHALL be PAT -> PMT -> SDT -> PAT (2-bit index; wraps from 2 to 0).
REQ-023 WAIT_DONE watchdog SHALL count cycles; at TIMEOUT cycles without TBL_DONE: ERR_TIMEOUT pulse, TABLE_SENT pulse, rotation advances, -> IDLE.
REQ-024 TBL_DONE and watchdog expiry in the same cycle SHALL be treated as a normal completion (no ERR_TIMEOUT).
REQ-025 PKT_DONE SHALL be counted in every state, including the cycle of any transition.
REQ-026 TBL_DONE outside WAIT_DONE SHALL be ignored.
REQ-027 Slot due and TABLE_SENT in the same cycle SHALL NOT increment MISSED; the next state SHALL be PENDING instead of IDLE.

Reset
REQ-028 RST=0 at a rising edge SHALL force: state IDLE, pkt_cnt 0, rotation 0, watchdog 0, MISSED 0, and TABLE_READY, TABLE_SENT, TBL_GO, ERR_TIMEOUT all 0; TBL_SEL 0.
REQ-029 Reset mid-transmission SHALL abandon the table silently, with no TABLE_SENT or ERR_TIMEOUT pulse.
REQ-030 Inputs SHALL be ignored while RST=0; the first PKT_DONE after release SHALL be counted as packet 1.

Configuration
REQ-031 Macro TS_SDT_TABLE_EN, when defined, SHALL include SDT in the rotation (PAT, PMT, SDT).
REQ-032 When TS_SDT_TABLE_EN is undefined, the rotation SHALL be PAT, PMT only (index wraps from 1 to 0), and TBL_SEL SHALL never equal 2.

Verification
REQ-033 INTERVAL=4: 4 PKT_DONE pulses -> TABLE_READY=1 one cycle after the 4th; START -> TBL_GO one cycle later with TBL_SEL=0.
REQ-034 Three full grant cycles with TBL_DONE each -> TBL_SEL sequence 0,1,2, then 0 on the 4th grant; with the macro undefined -> 0,1,0.
REQ-035 No START while 8 further PKT_DONE pulses arrive at INTERVAL=4 -> MISSED=2, TABLE_READY still 1, only one grant occurs.
REQ-036 TIMEOUT=10, TBL_DONE withheld -> exactly 10 cycles after TBL_GO: ERR_TIMEOUT and TABLE_SENT pulse together, next TBL_SEL=1.
REQ-037 RST low for one cycle during WAIT_DONE -> all outputs 0 and state_mon=0 the next cycle; no TABLE_SENT; the next grant uses TBL_SEL=0.
REQ-038 TBL_DONE coincident with the slot-due PKT_DONE -> TABLE_SENT pulse, MISSED unchanged, TABLE_READY=1 on the following cycle.
